// File: rtl/video_mnist_seg_argmax_if.sv
// AXI4-Stream pixel bus carrying per-class vote counts in and the classification
// sideband (tnumber/tcount/tbinary/tdetection) out.
interface video_mnist_seg_argmax_if #(
    parameter int unsigned TUSER_WIDTH   = 1,
    parameter int unsigned TDATA_WIDTH   = 24,
    parameter int unsigned NUM_CLASS     = 11,
    parameter int unsigned TNUMBER_WIDTH = 4,
    parameter int unsigned TCOUNT_WIDTH  = 4
) ();
    logic [TUSER_WIDTH-1:0]            tuser;
    logic                              tlast;
    logic [TDATA_WIDTH-1:0]            tdata;
    logic [NUM_CLASS*TCOUNT_WIDTH-1:0] tclass;
    logic [TNUMBER_WIDTH-1:0]          tnumber;
    logic [TCOUNT_WIDTH-1:0]           tcount;
    logic                              tbinary;
    logic                              tdetection;
    logic                              tvalid;
    logic                              tready;

    modport master (
        output tuser, tlast, tdata, tclass, tnumber, tcount, tbinary, tdetection, tvalid,
        input  tready
    );

    modport slave (
        input  tuser, tlast, tdata, tclass, tnumber, tcount, tbinary, tdetection, tvalid,
        output tready
    );
endinterface

// File: rtl/video_mnist_seg_argmax.sv
// Per-pixel argmax over packed class votes plus luminance threshold, pipelined with a global
// stall. Optional runner-up margin on detection: define VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN.
module video_mnist_seg_argmax #(
    parameter int unsigned TUSER_WIDTH   = 1,
    parameter int unsigned TDATA_WIDTH   = 24,
    parameter int unsigned NUM_CLASS     = 11,
    parameter int unsigned TNUMBER_WIDTH = 4,
    parameter int unsigned TCOUNT_WIDTH  = 4
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [7:0]                param_binary_th,
`ifdef VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN
    input  logic [TCOUNT_WIDTH-1:0]   param_margin,
`endif
    video_mnist_seg_argmax_if.slave   s_axi4s,
    video_mnist_seg_argmax_if.master  m_axi4s
);
    localparam int unsigned K  = $clog2(NUM_CLASS);
    localparam int unsigned BG = NUM_CLASS - 1;

    // Number of live nodes at tree level lvl (level 0 = one leaf per class).
    function automatic int unsigned nodes_at(input int unsigned lvl);
        int unsigned n;
        n = NUM_CLASS;
        for (int unsigned i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic logic [TCOUNT_WIDTH-1:0] max2(input logic [TCOUNT_WIDTH-1:0] x,
                                                     input logic [TCOUNT_WIDTH-1:0] y);
        return (x > y) ? x : y;
    endfunction

    logic                      w_cke;
    logic [9:0]                w_sum;
    logic [7:0]                w_luma;
    logic                      w_bin;

    logic [K:0]                r_valid;
    logic [K:0]                r_last;
    logic [K:0]                r_bin;
    logic [TUSER_WIDTH-1:0]    r_user [K+1];
    logic [TDATA_WIDTH-1:0]    r_data [K+1];

    logic [TCOUNT_WIDTH-1:0]   r_cnt [K+1][NUM_CLASS];
    logic [TNUMBER_WIDTH-1:0]  r_idx [K+1][NUM_CLASS];
    logic [TCOUNT_WIDTH-1:0]   w_cnt [K+1][NUM_CLASS];
    logic [TNUMBER_WIDTH-1:0]  w_idx [K+1][NUM_CLASS];
`ifdef VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN
    logic [TCOUNT_WIDTH-1:0]   r_sec [K+1][NUM_CLASS];
    logic [TCOUNT_WIDTH-1:0]   w_sec [K+1][NUM_CLASS];
`endif

    logic [TCOUNT_WIDTH-1:0]   w_best_cnt;
    logic [TNUMBER_WIDTH-1:0]  w_best_idx;
    logic [TNUMBER_WIDTH-1:0]  w_number;
    logic                      w_det;

    assign w_cke          = m_axi4s.tready | ~m_axi4s.tvalid;
    assign s_axi4s.tready = w_cke;

    assign w_sum  = {2'b00, s_axi4s.tdata[23:16]} + {1'b0, s_axi4s.tdata[15:8], 1'b0}
                  + {2'b00, s_axi4s.tdata[7:0]};
    assign w_luma = w_sum[9:2];
    assign w_bin  = (w_luma >= param_binary_th);

    // Level 0 comes straight from the input; level l is built from the level l-1 registers.
    always_comb begin
        int unsigned a;
        int unsigned b;
        a = 0;
        b = 0;
        for (int unsigned l = 0; l <= K; l++) begin
            for (int unsigned j = 0; j < NUM_CLASS; j++) begin
                w_cnt[l][j] = '0;
                w_idx[l][j] = '0;
`ifdef VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN
                w_sec[l][j] = '0;
`endif
            end
        end
        for (int unsigned i = 0; i < NUM_CLASS; i++) begin
            w_cnt[0][i] = s_axi4s.tclass[i*TCOUNT_WIDTH +: TCOUNT_WIDTH];
            w_idx[0][i] = TNUMBER_WIDTH'(i);
        end
        for (int unsigned l = 1; l <= K; l++) begin
            for (int unsigned j = 0; j < NUM_CLASS; j++) begin
                if (j < nodes_at(l)) begin
                    a = (2 * j < NUM_CLASS) ? 2 * j : 0;
                    b = (2 * j + 1 < NUM_CLASS) ? 2 * j + 1 : a;
                    w_cnt[l][j] = r_cnt[l-1][a];
                    w_idx[l][j] = r_idx[l-1][a];
`ifdef VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN
                    w_sec[l][j] = r_sec[l-1][a];
`endif
                    if (2 * j + 1 < nodes_at(l - 1)) begin
                        // Strict compare keeps the lower index on a tie.
                        if (r_cnt[l-1][b] > r_cnt[l-1][a]) begin
                            w_cnt[l][j] = r_cnt[l-1][b];
                            w_idx[l][j] = r_idx[l-1][b];
                        end
`ifdef VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN
                        w_sec[l][j] = max2(max2(r_sec[l-1][a], r_sec[l-1][b]),
                            (r_cnt[l-1][b] > r_cnt[l-1][a]) ? r_cnt[l-1][a] : r_cnt[l-1][b]);
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_valid <= '0;
            r_last  <= '0;
            r_bin   <= '0;
            for (int unsigned l = 0; l <= K; l++) begin
                r_user[l] <= '0;
                r_data[l] <= '0;
                for (int unsigned j = 0; j < NUM_CLASS; j++) begin
                    r_cnt[l][j] <= '0;
                    r_idx[l][j] <= '0;
`ifdef VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN
                    r_sec[l][j] <= '0;
`endif
                end
            end
        end else if (w_cke) begin
            r_valid <= {r_valid[K-1:0], s_axi4s.tvalid};
            r_last  <= {r_last[K-1:0], s_axi4s.tlast};
            r_bin   <= {r_bin[K-1:0], w_bin};
            r_user[0] <= s_axi4s.tuser;
            r_data[0] <= s_axi4s.tdata;
            for (int unsigned l = 1; l <= K; l++) begin
                r_user[l] <= r_user[l-1];
                r_data[l] <= r_data[l-1];
            end
            for (int unsigned l = 0; l <= K; l++) begin
                for (int unsigned j = 0; j < NUM_CLASS; j++) begin
                    r_cnt[l][j] <= w_cnt[l][j];
                    r_idx[l][j] <= w_idx[l][j];
`ifdef VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN
                    r_sec[l][j] <= w_sec[l][j];
`endif
                end
            end
        end
    end

    assign w_best_cnt = r_cnt[K][0];
    assign w_best_idx = r_idx[K][0];

    // Zero votes means nothing was seen: report background. Gated by valid so idle outputs are 0.
    always_comb begin
        w_number = '0;
        w_det    = 1'b0;
        if (r_valid[K]) begin
            if (w_best_cnt == '0) begin
                w_number = TNUMBER_WIDTH'(BG);
            end else begin
                w_number = w_best_idx;
                w_det    = (w_best_idx != TNUMBER_WIDTH'(BG));
`ifdef VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN
                w_det    = w_det && ((w_best_cnt - r_sec[K][0]) >= param_margin);
`endif
            end
        end
    end

    assign m_axi4s.tvalid     = r_valid[K];
    assign m_axi4s.tuser      = r_user[K];
    assign m_axi4s.tlast      = r_last[K];
    assign m_axi4s.tdata      = r_data[K];
    assign m_axi4s.tclass     = '0;
    assign m_axi4s.tnumber    = w_number;
    assign m_axi4s.tcount     = w_best_cnt;
    assign m_axi4s.tbinary    = r_bin[K];
    assign m_axi4s.tdetection = w_det;
endmodule

// File: tb/tb_video_mnist_seg_argmax.sv
// Randomised and directed bench for video_mnist_seg_argmax against a plain argmax model.
module tb_video_mnist_seg_argmax;
    localparam int NC  = 11;
    localparam int CW  = 4;
    localparam int LAT = 5;

    typedef struct packed {
        logic        user;
        logic        last;
        logic [23:0] data;
        logic [3:0]  number;
        logic [3:0]  count;
        logic        bin;
        logic        det;
    } exp_t;

    logic       aclk = 1'b0;
    logic       areset;
    logic [7:0] th;
    logic [3:0] margin;
    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       q[$];

    video_mnist_seg_argmax_if #(.TUSER_WIDTH(1), .TDATA_WIDTH(24), .NUM_CLASS(NC),
                                .TNUMBER_WIDTH(4), .TCOUNT_WIDTH(CW)) s_if ();
    video_mnist_seg_argmax_if #(.TUSER_WIDTH(1), .TDATA_WIDTH(24), .NUM_CLASS(NC),
                                .TNUMBER_WIDTH(4), .TCOUNT_WIDTH(CW)) m_if ();

    video_mnist_seg_argmax #(.TUSER_WIDTH(1), .TDATA_WIDTH(24), .NUM_CLASS(NC),
                             .TNUMBER_WIDTH(4), .TCOUNT_WIDTH(CW)) dut (
        .aclk            (aclk),
        .areset          (areset),
        .param_binary_th (th),
`ifdef VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN
        .param_margin    (margin),
`endif
        .s_axi4s         (s_if.slave),
        .m_axi4s         (m_if.master)
    );

    always #5 aclk = ~aclk;

    // Reference: first maximum wins, zero votes means background, runner-up is 2nd largest.
    function automatic exp_t model(input logic [NC*CW-1:0] cls, input logic [23:0] d,
                                   input logic u, input logic l, input logic [7:0] thr,
                                   input logic [3:0] mg);
        exp_t e;
        int best, bi, second, c, y;
        best = -1; bi = 0; second = 0;
        for (int i = 0; i < NC; i++) begin
            c = int'(cls[i*CW +: CW]);
            if (c > best) begin
                if (best > second) second = best;
                best = c;
                bi   = i;
            end else if (c > second) begin
                second = c;
            end
        end
        y = (int'(d[23:16]) + 2 * int'(d[15:8]) + int'(d[7:0])) / 4;
        e.user   = u;
        e.last   = l;
        e.data   = d;
        e.count  = 4'(best);
        e.bin    = (y >= int'(thr));
        e.number = (best == 0) ? 4'(NC - 1) : 4'(bi);
        e.det    = (best != 0) && (bi != NC - 1);
`ifdef VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN
        e.det    = e.det && ((best - second) >= int'(mg));
`else
        if (mg == 4'hF && second < 0) e.det = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t e;
        e.user   = m_if.tuser;
        e.last   = m_if.tlast;
        e.data   = m_if.tdata;
        e.number = m_if.tnumber;
        e.count  = m_if.tcount;
        e.bin    = m_if.tbinary;
        e.det    = m_if.tdetection;
        return e;
    endfunction

    function automatic logic [NC*CW-1:0] rand_cls();
        logic [NC*CW-1:0] c;
        int mode;
        mode = int'($urandom_range(0, 7));
        for (int i = 0; i < NC; i++) begin
            c[i*CW +: CW] = 4'($urandom_range(0, (mode == 2) ? 3 : 15));
            if (mode == 0 || (mode == 1 && i != NC - 1)) c[i*CW +: CW] = 4'd0;
        end
        return c;
    endfunction

    function automatic logic [NC*CW-1:0] fill(input int v);
        logic [NC*CW-1:0] c;
        for (int i = 0; i < NC; i++) c[i*CW +: CW] = 4'(v);
        return c;
    endfunction

    task automatic drive_in(input logic v, input logic [NC*CW-1:0] cls, input logic [23:0] d,
                            input logic u, input logic l);
        s_if.tvalid = v;
        s_if.tclass = cls;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        m_if.tready = 1'b1;
        drive_in(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge aclk);
        #1;
        n_checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tdata !== 24'd0 || m_if.tnumber !== 4'd0 ||
            m_if.tcount !== 4'd0 || m_if.tdetection !== 1'b0 || m_if.tbinary !== 1'b0 ||
            m_if.tuser !== 1'b0 || m_if.tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b data=%h num=%0d cnt=%0d det=%b, want all 0",
                     m_if.tvalid, m_if.tdata, m_if.tnumber, m_if.tcount, m_if.tdetection);
        end
        n_checks++;
        if (s_if.tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tready: got %b want 1", s_if.tready);
        end
        areset = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_directed();
        logic [NC*CW-1:0] cls [4];
        logic [23:0]      dat [4];
        exp_t             want [4];
        exp_t             got;
        th = 8'd100;
        cls[0] = fill(2);  cls[0][3*CW +: CW] = 4'd9;
        cls[1] = fill(0);  cls[1][5*CW +: CW] = 4'd6;  cls[1][7*CW +: CW] = 4'd6;
        cls[2] = fill(0);
        cls[3] = fill(0);  cls[3][10*CW +: CW] = 4'd12;
        dat[0] = 24'h808080; dat[1] = 24'h000000; dat[2] = 24'hFFFFFF; dat[3] = 24'h102030;
        want[0] = '{user: 1'b1, last: 1'b0, data: 24'h808080, number: 4'd3,  count: 4'd9,
                    bin: 1'b1, det: 1'b1};
        want[1] = '{user: 1'b0, last: 1'b1, data: 24'h000000, number: 4'd5,  count: 4'd6,
                    bin: 1'b0, det: 1'b1};
        want[2] = '{user: 1'b1, last: 1'b0, data: 24'hFFFFFF, number: 4'd10, count: 4'd0,
                    bin: 1'b1, det: 1'b0};
        want[3] = '{user: 1'b0, last: 1'b1, data: 24'h102030, number: 4'd10, count: 4'd12,
                    bin: 1'b0, det: 1'b0};
        m_if.tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_in(1'b1, cls[k], dat[k], want[k].user, want[k].last);
            @(posedge aclk); #1;
            drive_in(1'b0, '0, '0, 1'b0, 1'b0);
            repeat (LAT - 2) @(posedge aclk);
            #1;
            n_checks++;
            if (m_if.tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_early_%0d: tvalid got %b want 0 at cycle %0d",
                         k, m_if.tvalid, LAT - 1);
            end
            @(posedge aclk); #1;
            got = sample();
            n_checks++;
            if (m_if.tvalid !== 1'b1 || got !== want[k]) begin
                n_fail++;
                $display("FAIL directed_%0d: got valid=%b %p want %p", k, m_if.tvalid, got,
                         want[k]);
            end
            @(posedge aclk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t want [20];
        logic [NC*CW-1:0] c;
        logic [23:0] d;
        exp_t got;
        th = 8'($urandom_range(0, 255));
        m_if.tready = 1'b1;
        for (int cyc = 0; cyc < 20 + LAT + 2; cyc++) begin
            if (cyc < 20) begin
                c = rand_cls();
                d = 24'($urandom);
                want[cyc] = model(c, d, cyc == 0, cyc == 19, th, margin);
                drive_in(1'b1, c, d, cyc == 0, cyc == 19);
            end else begin
                drive_in(1'b0, '0, '0, 1'b0, 1'b0);
            end
            #1;
            if (cyc >= LAT && cyc - LAT < 20) begin
                got = sample();
                n_checks++;
                if (m_if.tvalid !== 1'b1 || got !== want[cyc-LAT]) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got valid=%b %p want %p", cyc - LAT, m_if.tvalid,
                             got, want[cyc-LAT]);
                end
            end
            @(posedge aclk); #1;
        end
    endtask

    task automatic test_stream();
        int   sent = 0, got_n = 0, cyc = 0, extra = 0;
        logic have = 1'b0, prev_stall = 1'b0;
        logic [NC*CW-1:0] c;
        logic [23:0] d;
        exp_t held, got, want;
        q.delete();
        th = 8'($urandom_range(0, 255));
        c = '0;
        d = '0;
        while (got_n < 64 && cyc < 3000) begin
            m_if.tready = ($urandom_range(0, 2) != 0);
            if (!have && sent < 64 && $urandom_range(0, 3) != 0) begin
                c = rand_cls();
                d = 24'($urandom);
                have = 1'b1;
            end
            drive_in(have, c, d, sent == 0, (sent % 8) == 7);
            #1;
            if (prev_stall) begin
                got = sample();
                n_checks++;
                if (m_if.tvalid !== 1'b1 || got !== held) begin
                    n_fail++;
                    $display("FAIL stall_stable: got valid=%b %p want %p", m_if.tvalid, got,
                             held);
                end
            end
            if (s_if.tvalid && s_if.tready) begin
                q.push_back(model(c, d, sent == 0, (sent % 8) == 7, th, margin));
                sent++;
                have = 1'b0;
            end
            if (m_if.tvalid && m_if.tready) begin
                got = sample();
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_unexpected: got %p want nothing", got);
                end else begin
                    want = q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL stream_%0d: got %p want %p", got_n, got, want);
                    end
                end
                got_n++;
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            if (prev_stall) held = sample();
            @(posedge aclk); #1;
            cyc++;
        end
        n_checks++;
        if (got_n != 64 || sent != 64) begin
            n_fail++;
            $display("FAIL stream_count: got %0d out / %0d in want 64", got_n, sent);
        end
        m_if.tready = 1'b1;
        drive_in(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (LAT + 3) begin
            #1;
            if (m_if.tvalid) extra++;
            @(posedge aclk); #1;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL stream_extra: got %0d extra beats want 0", extra);
        end
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        m_if.tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_in(1'b1, rand_cls(), 24'($urandom), 1'b0, 1'b0);
            @(posedge aclk); #1;
        end
        drive_in(1'b0, '0, '0, 1'b0, 1'b0);
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        n_checks++;
        if (m_if.tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_valid: got %b want 0", m_if.tvalid);
        end
        repeat (LAT + 5) begin
            if (m_if.tvalid) seen++;
            @(posedge aclk); #1;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midreset_leak: got %0d beats want 0", seen);
        end
    endtask

`ifdef VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN
    task automatic test_margin();
        logic [NC*CW-1:0] c [2];
        logic want_det [2];
        margin = 4'd3;
        c[0] = fill(1); c[0][2*CW +: CW] = 4'd8; c[0][4*CW +: CW] = 4'd6;
        c[1] = fill(0); c[1][2*CW +: CW] = 4'd8; c[1][6*CW +: CW] = 4'd5;
        want_det[0] = 1'b0;
        want_det[1] = 1'b1;
        m_if.tready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive_in(1'b1, c[k], 24'h0, 1'b0, 1'b0);
            @(posedge aclk); #1;
            drive_in(1'b0, '0, '0, 1'b0, 1'b0);
            repeat (LAT - 1) @(posedge aclk);
            #1;
            n_checks++;
            if (m_if.tvalid !== 1'b1 || m_if.tdetection !== want_det[k] ||
                m_if.tnumber !== 4'd2 || m_if.tcount !== 4'd8) begin
                n_fail++;
                $display("FAIL margin_%0d: got valid=%b det=%b num=%0d cnt=%0d want det=%b",
                         k, m_if.tvalid, m_if.tdetection, m_if.tnumber, m_if.tcount,
                         want_det[k]);
            end
            @(posedge aclk); #1;
        end
    endtask
`endif

    initial begin
        areset = 1'b1;
        th     = 8'd0;
        margin = 4'd0;
        s_if.tnumber = '0;
        s_if.tcount = '0;
        s_if.tbinary = 1'b0;
        s_if.tdetection = 1'b0;
        drive_in(1'b0, '0, '0, 1'b0, 1'b0);
        m_if.tready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stream();
        test_reset_midstream();
`ifdef VIDEO_MNIST_SEG_ARGMAX_MARGIN_EN
        test_margin();
        margin = 4'd0;
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
